// File: rtl/clk_pkg.sv
// Shared constants, time-of-day record and display helper for the real-time clock.
// No ports: package imported by digital_clk_cfg.
package clk_pkg;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned SEC_W    = 6;
    localparam int unsigned MIN_W    = 6;
    localparam int unsigned HOUR_W   = 5;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } clk_time_t;

    // 24-h internal hour to 12-h display hour: 0 -> 12, 13..23 -> 1..11.
    function automatic logic [HOUR_W-1:0] hour_12h(input logic [HOUR_W-1:0] h);
        if (h == '0) begin
            return HOUR_W'(12);
        end else if (h > HOUR_W'(12)) begin
            return h - HOUR_W'(12);
        end else begin
            return h;
        end
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// One-second prescaler: counts 0..TICK_DIV-1 and flags the last count.
// Ports:
//   clk_i   - clock
//   reset_i - asynchronous active-high reset, clears the count
//   clear   - synchronous clear; also suppresses tick in the same cycle
//   tick    - high while the count sits at TICK_DIV-1 (and not cleared/reset)
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wrap;

    always_comb begin
        wrap  = (cnt_q == CntMax);
        cnt_d = (clear || wrap) ? '0 : cnt_q + 1'b1;
        // Reset gating keeps tick low during reset even when TICK_DIV=1.
        tick  = wrap && !clear && !reset_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/digital_clk_cfg.sv
// Settable 24-h real-time clock with 12/24-h display, load range checking and alarm.
// Ports:
//   clk_i, reset_i                  - clock, asynchronous active-high reset
//   Timeset, Hourset/Minset/Secset  - time load request and fields (24-h)
//   mode24_i                        - 1: 24-h display, 0: 12-h display
//   alarm_en_i, alarm_hour_i/min_i  - alarm enable and alarm time
//   sec_o, min_o, hour_o, pm_o      - displayed time and PM flag
//   tick_o                          - one-cycle pulse per second advance
//   alarm_o                         - one-cycle pulse after reaching alarm time
//   set_err_o                       - high in each cycle a load is rejected
module digital_clk_cfg
    import clk_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1,
    parameter int unsigned ALARM_EN_P = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              Timeset,
    input  logic [HOUR_W-1:0] Hourset,
    input  logic [MIN_W-1:0]  Minset,
    input  logic [SEC_W-1:0]  Secset,
    input  logic              mode24_i,
    input  logic              alarm_en_i,
    input  logic [HOUR_W-1:0] alarm_hour_i,
    input  logic [MIN_W-1:0]  alarm_min_i,
    output logic [SEC_W-1:0]  sec_o,
    output logic [MIN_W-1:0]  min_o,
    output logic [HOUR_W-1:0] hour_o,
    output logic              pm_o,
    output logic              tick_o,
    output logic              alarm_o,
    output logic              set_err_o
);

    clk_time_t time_q, time_d;
    logic      alarm_q, alarm_d;
    logic      tick;
    logic      load_valid;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear   (Timeset),
        .tick    (tick)
    );

    always_comb begin
        load_valid = (Hourset <= HOUR_W'(HOUR_MAX)) && (Minset <= MIN_W'(MIN_MAX)) &&
                     (Secset <= SEC_W'(SEC_MAX));
        time_d     = time_q;
        alarm_d    = 1'b0;
        if (Timeset) begin
            // Load wins over any coincident tick; a bad field rejects the whole load.
            if (load_valid) begin
                time_d = '{hour: Hourset, min: Minset, sec: Secset};
            end
        end else if (tick) begin
            if (time_q.sec == SEC_W'(SEC_MAX)) begin
                time_d.sec = '0;
                if (time_q.min == MIN_W'(MIN_MAX)) begin
                    time_d.min  = '0;
                    time_d.hour = (time_q.hour == HOUR_W'(HOUR_MAX)) ? '0
                                                                     : time_q.hour + 1'b1;
                end else begin
                    time_d.min = time_q.min + 1'b1;
                end
            end else begin
                time_d.sec = time_q.sec + 1'b1;
            end
            if (ALARM_EN_P != 0 && alarm_en_i && time_d.hour == alarm_hour_i &&
                time_d.min == alarm_min_i && time_d.sec == '0) begin
                alarm_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            time_q  <= '0;
            alarm_q <= 1'b0;
        end else begin
            time_q  <= time_d;
            alarm_q <= alarm_d;
        end
    end

    always_comb begin
        sec_o     = time_q.sec;
        min_o     = time_q.min;
        hour_o    = mode24_i ? time_q.hour : hour_12h(time_q.hour);
        pm_o      = (time_q.hour >= HOUR_W'(12));
        tick_o    = tick;
        alarm_o   = alarm_q;
        set_err_o = Timeset && !load_valid && !reset_i;
    end

endmodule

// File: tb/tb_digital_clk_cfg.sv
// Bench for digital_clk_cfg: two instances (TICK_DIV=1 and 4) share all inputs and are
// checked each cycle against a seconds-of-day reference model.
module tb_digital_clk_cfg;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       Timeset;
    logic [4:0] Hourset;
    logic [5:0] Minset, Secset;
    logic       mode24_i;
    logic       alarm_en_i;
    logic [4:0] alarm_hour_i;
    logic [5:0] alarm_min_i;

    logic [5:0] sec1, min1, sec4, min4;
    logic [4:0] hour1, hour4;
    logic       pm1, tick1, alarm1, err1, pm4, tick4, alarm4, err4;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state per instance
    int tod [2];
    int pc  [2];
    int alm [2];
    int divs[2] = '{1, 4};

    always #5 clk = ~clk;

    digital_clk_cfg #(.TICK_DIV(1), .ALARM_EN_P(1)) u_div1 (
        .clk_i(clk), .reset_i(reset_i), .Timeset(Timeset), .Hourset(Hourset),
        .Minset(Minset), .Secset(Secset), .mode24_i(mode24_i), .alarm_en_i(alarm_en_i),
        .alarm_hour_i(alarm_hour_i), .alarm_min_i(alarm_min_i), .sec_o(sec1), .min_o(min1),
        .hour_o(hour1), .pm_o(pm1), .tick_o(tick1), .alarm_o(alarm1), .set_err_o(err1)
    );

    digital_clk_cfg #(.TICK_DIV(4), .ALARM_EN_P(1)) u_div4 (
        .clk_i(clk), .reset_i(reset_i), .Timeset(Timeset), .Hourset(Hourset),
        .Minset(Minset), .Secset(Secset), .mode24_i(mode24_i), .alarm_en_i(alarm_en_i),
        .alarm_hour_i(alarm_hour_i), .alarm_min_i(alarm_min_i), .sec_o(sec4), .min_o(min4),
        .hour_o(hour4), .pm_o(pm4), .tick_o(tick4), .alarm_o(alarm4), .set_err_o(err4)
    );

    function automatic bit load_ok();
        return (int'(Hourset) <= 23) && (int'(Minset) <= 59) && (int'(Secset) <= 59);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            tod[k] = 0;
            pc[k]  = 0;
            alm[k] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic model_edge();
        if (reset_i) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            alm[k] = 0;
            if (Timeset) begin
                pc[k] = 0;
                if (load_ok())
                    tod[k] = int'(Hourset) * 3600 + int'(Minset) * 60 + int'(Secset);
            end else if (pc[k] == divs[k] - 1) begin
                pc[k]  = 0;
                tod[k] = (tod[k] + 1) % 86400;
                alm[k] = (alarm_en_i &&
                          tod[k] == int'(alarm_hour_i) * 3600 + int'(alarm_min_i) * 60) ? 1 : 0;
            end else begin
                pc[k] = pc[k] + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input string tag, input int k, input logic [5:0] s,
                              input logic [5:0] m, input logic [4:0] h, input logic pm,
                              input logic tk, input logic al, input logic se);
        int eh, dh;
        eh = tod[k] / 3600;
        if (mode24_i)      dh = eh;
        else if (eh == 0)  dh = 12;
        else if (eh > 12)  dh = eh - 12;
        else               dh = eh;
        chk({tag, "/sec"},  32'(s),  32'(tod[k] % 60));
        chk({tag, "/min"},  32'(m),  32'((tod[k] / 60) % 60));
        chk({tag, "/hour"}, 32'(h),  32'(dh));
        chk({tag, "/pm"},   32'(pm), 32'(eh >= 12));
        chk({tag, "/tick"}, 32'(tk), 32'(!reset_i && !Timeset && pc[k] == divs[k] - 1));
        chk({tag, "/alarm"}, 32'(al), 32'(alm[k]));
        chk({tag, "/set_err"}, 32'(se), 32'(!reset_i && Timeset && !load_ok()));
    endtask

    task automatic check_all(input string tag);
        #1;
        check_inst({tag, "/div1"}, 0, sec1, min1, hour1, pm1, tick1, alarm1, err1);
        check_inst({tag, "/div4"}, 1, sec4, min4, hour4, pm4, tick4, alarm4, err4);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_load(input bit ts, input int h, input int m, input int s);
        Timeset = ts;
        Hourset = 5'(h);
        Minset  = 6'(m);
        Secset  = 6'(s);
    endtask

    int pulses;

    initial begin
        reset_i = 1'b1;
        set_load(0, 0, 0, 0);
        mode24_i = 1'b0;
        alarm_en_i = 1'b0;
        alarm_hour_i = '0;
        alarm_min_i = '0;
        model_reset();

        // Reset state in both display modes
        @(negedge clk);
        check_all("reset12");
        mode24_i = 1'b1;
        check_all("reset24");
        step();
        check_all("reset_held");
        reset_i = 1'b0;
        mode24_i = 1'b0;

        // 11:59:59 -> noon in 12-h mode
        set_load(1, 11, 59, 59);
        check_all("load1159");
        step();
        Timeset = 1'b0;
        check_all("shown1159");
        step();
        check_all("noon");

        // 23:59:59 -> midnight, both display modes
        mode24_i = 1'b1;
        set_load(1, 23, 59, 59);
        step();
        Timeset = 1'b0;
        check_all("shown2359");
        step();
        check_all("midnight24");
        mode24_i = 1'b0;
        check_all("midnight12");

        // Count from 00:00:00 for 12 cycles (div4 reaches sec 3)
        set_load(1, 0, 0, 0);
        step();
        Timeset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check_all("count");
            step();
        end
        check_all("count_end");

        // Rejected loads: Minset=60, then Hourset=24
        set_load(1, 5, 60, 0);
        check_all("bad_min");
        step();
        set_load(1, 24, 0, 0);
        check_all("bad_hour");
        step();
        Timeset = 1'b0;
        check_all("after_bad");

        // Alarm at 07:30, enabled then disabled
        for (int pass = 0; pass < 2; pass++) begin
            alarm_en_i = (pass == 0);
            alarm_hour_i = 5'd7;
            alarm_min_i = 6'd30;
            set_load(1, 7, 29, 59);
            step();
            Timeset = 1'b0;
            pulses = 0;
            for (int i = 0; i < 12; i++) begin
                check_all("alarm");
                if (alarm1 === 1'b1) pulses++;
                step();
            end
            chk("alarm_pulses_div1", 32'(pulses), 32'(pass == 0 ? 1 : 0));
        end

        // Randomized operation
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                alarm_hour_i = 5'(((tod[0] / 60 + 1) % 1440) / 60);
                alarm_min_i  = 6'((tod[0] / 60 + 1) % 60);
            end
            set_load($urandom_range(0, 15) == 0, $urandom_range(0, 25), $urandom_range(0, 61),
                     $urandom_range(0, 61));
            mode24_i = 1'($urandom_range(0, 1));
            alarm_en_i = ($urandom_range(0, 3) != 0);
            check_all("rand");
            step();
        end

        // Asynchronous reset mid-count at 05:12:40
        mode24_i = 1'b0;
        set_load(1, 5, 12, 40);
        step();
        Timeset = 1'b0;
        step();
        step();
        check_all("pre_reset");
        #2;
        reset_i = 1'b1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        reset_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_all("post_reset");
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/digital_clk_cfg.md
DIGITAL_CLK_CFG -- requirements
Module: digital_clk_cfg

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1: clk_i cycles per one-second tick, range 1 to 2^24.
REQ-002 SHALL have parameter ALARM_EN_P, default 1: 1 includes the alarm logic; 0 ties alarm_o low.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state on rising edge.
REQ-004 SHALL have port reset_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port Timeset, input, 1 bit: load Hourset/Minset/Secset while high.
REQ-006 SHALL have port Hourset, input, 5 bits: hour to load, 24-h encoding 0-23.
REQ-007 SHALL have ports Minset and Secset, input, 6 bits each: minute/second to load, 0-59.
REQ-008 SHALL have port mode24_i, input, 1 bit: 1 = 24-h display, 0 = 12-h display.
REQ-009 SHALL have ports alarm_en_i (1 bit), alarm_hour_i (5 bits, 24-h) and alarm_min_i (6 bits), all inputs: alarm control.
REQ-010 SHALL have ports sec_o and min_o, output, 6 bits each: current second/minute.
REQ-011 SHALL have port hour_o, output, 5 bits: displayed hour, 0-23 in 24-h mode, 1-12 in 12-h mode.
REQ-012 SHALL have port pm_o, output, 1 bit: 1 when internal hour is 12-23, valid in both modes.
REQ-013 SHALL have port tick_o, output, 1 bit: one-cycle pulse on each second increment.
REQ-014 SHALL have port alarm_o, output, 1 bit: one-cycle alarm pulse.
REQ-015 SHALL have port set_err_o, output, 1 bit: one-cycle pulse on a rejected load.

Function
REQ-016 SHALL keep time internally as a 24-h hour (0-23), minute and second; display mapping is combinational from this state.
REQ-017 SHALL run a prescaler from 0 to TICK_DIV-1; tick_o SHALL be high in the cycle the prescaler is at TICK_DIV-1, and the time SHALL advance on that edge.
REQ-018 SHALL, with TICK_DIV=1, assert tick_o every cycle and advance the time every cycle.
REQ-019 SHALL cascade increments: sec 59 -> 0 carries to min; min 59 -> 0 carries to hour; hour 23 -> 0, with all three fields updated on the same edge.
REQ-020 SHALL map the 12-h display as: hour_o = 12 for internal 0 and 12; hour_o = h-12 for internal 13-23; otherwise hour_o = h.
REQ-021 SHALL make mode24_i changes affect hour_o combinationally, with no effect on the internal count.
REQ-022 SHALL, while Timeset=1, check Hourset, Minset and Secset every cycle; if all fields are in range, it SHALL load them on the next edge.
REQ-023 SHALL, while Timeset=1, clear the prescaler, hold tick_o=0 and suspend counting.
REQ-024 SHALL, if any field is out of range (Hourset>23, Minset>59, Secset>59), reject the whole load, keep the current time and pulse set_err_o for one cycle per rejected cycle.
REQ-025 SHALL, after Timeset falls, make the first tick occur TICK_DIV cycles after the falling edge.
REQ-026 SHALL pulse alarm_o for one cycle on the tick edge where the time becomes alarm_hour_i:alarm_min_i:00 while alarm_en_i=1; Timeset loads SHALL never fire the alarm.
REQ-027 SHALL give Timeset priority over a coincident tick: the tick is dropped and the load wins.

Reset
REQ-028 SHALL, on reset_i high, immediately clear time to 00:00:00, clear the prescaler and drive tick_o, alarm_o and set_err_o to 0.
REQ-029 SHALL, during reset, drive hour_o to 12 with mode24_i=0 or 0 with mode24_i=1, and pm_o to 0.
REQ-030 SHALL, on reset assertion mid-count or mid-load, abort the operation with no partial update; counting SHALL restart from prescaler 0 after release.

Structure
REQ-031 SHALL place constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, SEC_W=6, MIN_W=6 and HOUR_W=5 in a shared package clk_pkg.
REQ-032 SHALL implement the prescaler as sub-module tick_prescaler (parameter TICK_DIV; inputs clk_i, reset_i, clear; output tick); the rest SHALL stay in digital_clk_cfg.

Verification
REQ-033 SHALL cover: TICK_DIV=1, Timeset=1 with 11:59:59 loaded, then Timeset=0, mode24_i=0 -> displays 11:59:59 pm_o=0; next tick 12:00:00 pm_o=1.
REQ-034 SHALL cover: load 23:59:59, mode24_i=1 -> one tick gives 00:00:00 pm_o=0; with mode24_i=0 -> 12:00:00.
REQ-035 SHALL cover: TICK_DIV=4, count from 00:00:00 -> tick_o every 4th cycle; sec_o=3 after 12 cycles.
REQ-036 SHALL cover: Timeset with Minset=60 -> time unchanged and set_err_o=1 for one cycle; with Hourset=24 -> same response.
REQ-037 SHALL cover: alarm at 07:30 with alarm_en_i=1 and 07:29:59 loaded -> alarm_o pulses exactly once, on 07:30:00; with alarm_en_i=0 -> no pulse.
REQ-038 SHALL cover: reset_i asserted asynchronously mid-count at 05:12:40 -> outputs 00:00:00 (hour_o=12 in 12-h mode) before the next clk_i edge.
